// File: rtl/aes_pkg.sv
// +--------------------------------------------------------------------------+
// | aes_pkg: shared AES state/column types and GF(2^8) helpers               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package aes_pkg;

    // Column c at [c*32 +: 32]; within a column, row 0 is the MSB byte.
    typedef logic [3:0][3:0][7:0] state_t;
    typedef logic [3:0][7:0]      col_t;

    localparam logic [3:0] GM_2 = 4'h2;
    localparam logic [3:0] GM_3 = 4'h3;
    localparam logic [3:0] GM_9 = 4'h9;
    localparam logic [3:0] GM_B = 4'hb;
    localparam logic [3:0] GM_D = 4'hd;
    localparam logic [3:0] GM_E = 4'he;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a small constant (at most 4 bits) modulo 0x11B.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] acc;
        logic [7:0] p;
        acc = '0;
        p   = a;
        for (int i = 0; i < 4; i++) begin
            if (k[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mix_column_unit.sv
// +--------------------------------------------------------------------------+
// | mix_column_unit: combinational single-column (Inv)MixColumns.            |
// | Inverse logic present only when MIXCOL_INV_EN is defined.  Revision: 1.0 |
// +--------------------------------------------------------------------------+
`default_nettype none

module mix_column_unit
    import aes_pkg::*;
(
    input  col_t col_in,
    input  logic inv,
    output col_t col_out
);

    logic [7:0] a0, a1, a2, a3;
    col_t       fwd;

    assign a0 = col_in[3];
    assign a1 = col_in[2];
    assign a2 = col_in[1];
    assign a3 = col_in[0];

    assign fwd[3] = gmul(a0, GM_2) ^ gmul(a1, GM_3) ^ a2 ^ a3;
    assign fwd[2] = a0 ^ gmul(a1, GM_2) ^ gmul(a2, GM_3) ^ a3;
    assign fwd[1] = a0 ^ a1 ^ gmul(a2, GM_2) ^ gmul(a3, GM_3);
    assign fwd[0] = gmul(a0, GM_3) ^ a1 ^ a2 ^ gmul(a3, GM_2);

`ifdef MIXCOL_INV_EN
    col_t rev;

    assign rev[3] = gmul(a0, GM_E) ^ gmul(a1, GM_B) ^ gmul(a2, GM_D) ^ gmul(a3, GM_9);
    assign rev[2] = gmul(a0, GM_9) ^ gmul(a1, GM_E) ^ gmul(a2, GM_B) ^ gmul(a3, GM_D);
    assign rev[1] = gmul(a0, GM_D) ^ gmul(a1, GM_9) ^ gmul(a2, GM_E) ^ gmul(a3, GM_B);
    assign rev[0] = gmul(a0, GM_B) ^ gmul(a1, GM_D) ^ gmul(a2, GM_9) ^ gmul(a3, GM_E);

    assign col_out = inv ? rev : fwd;
`else
    logic unused_inv;

    assign unused_inv = inv;
    assign col_out    = fwd;
`endif

endmodule

`default_nettype wire

// File: rtl/mix_columns_engine.sv
// +--------------------------------------------------------------------------+
// | mix_columns_engine: handshaked, column-serialisable (Inv)MixColumns.     |
// | Optional inverse mode via MIXCOL_INV_EN.                   Revision: 1.0 |
// +--------------------------------------------------------------------------+
`default_nettype none

module mix_columns_engine
    import aes_pkg::*;
#(
    parameter int HDR_W          = 4,
    parameter int COLS_PER_CYCLE = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 inv,
    input  logic [HDR_W+127:0]   data_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [HDR_W-1:0]     header_out,
    output logic [127:0]         data_out
);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_CNT = 2'(4 - COLS_PER_CYCLE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fsm_t;

    fsm_t             st;
    state_t           src;
    state_t           result;
    logic [HDR_W-1:0] hdr;
    logic             inv_q;
    logic [1:0]       col_cnt;
    logic             accept;
    col_t             col_src [COLS_PER_CYCLE];
    col_t             col_res [COLS_PER_CYCLE];

    assign in_ready = !rst && ((st == IDLE) || (st == DONE && out_ready));
    assign accept   = in_valid && in_ready;
    assign data_out = result;

    for (genvar i = 0; i < COLS_PER_CYCLE; i++) begin : g_cols
        assign col_src[i] = src[col_cnt + 2'(i)];

        mix_column_unit u_col (
            .col_in  (col_src[i]),
            .inv     (inv_q),
            .col_out (col_res[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st         <= IDLE;
            col_cnt    <= '0;
            src        <= '0;
            hdr        <= '0;
            inv_q      <= 1'b0;
            result     <= '0;
            header_out <= '0;
            out_valid  <= 1'b0;
        end else begin
            case (st)
                IDLE: begin
                    if (accept) st <= BUSY;
                end
                BUSY: begin
                    for (int i = 0; i < COLS_PER_CYCLE; i++) begin
                        result[col_cnt + 2'(i)] <= col_res[i];
                    end
                    col_cnt <= col_cnt + COL_STEP;
                    if (col_cnt == LAST_CNT) begin
                        st         <= DONE;
                        out_valid  <= 1'b1;
                        header_out <= hdr;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        st        <= in_valid ? BUSY : IDLE;
                    end
                end
                default: st <= IDLE;
            endcase

            // Accepting binds header and mode to the block for its whole journey.
            if (accept) begin
                src     <= data_in[127:0];
                hdr     <= data_in[HDR_W+127:128];
                inv_q   <= inv;
                col_cnt <= '0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mix_columns_engine.sv
// +--------------------------------------------------------------------------+
// | tb_mix_columns_engine: directed bench for 4-column and 1-column builds.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_mix_columns_engine;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    logic         a_in_valid, a_in_ready, a_inv, a_out_valid, a_out_ready;
    logic [131:0] a_data_in;
    logic [3:0]   a_header_out;
    logic [127:0] a_data_out;

    logic         b_in_valid, b_in_ready, b_inv, b_out_valid, b_out_ready;
    logic [131:0] b_data_in;
    logic [3:0]   b_header_out;
    logic [127:0] b_data_out;

    int vectors     = 0;
    int miscompares = 0;

`ifdef MIXCOL_INV_EN
    localparam logic [31:0] INV_COL = 32'hd4bf5d30;
`else
    localparam logic [31:0] INV_COL = 32'hc6b54f3a;
`endif

    mix_columns_engine #(.HDR_W(4), .COLS_PER_CYCLE(4)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .inv(a_inv),
        .data_in(a_data_in), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .header_out(a_header_out), .data_out(a_data_out)
    );

    mix_columns_engine #(.HDR_W(4), .COLS_PER_CYCLE(1)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .inv(b_inv),
        .data_in(b_data_in), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .header_out(b_header_out), .data_out(b_data_out)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_a(input logic [3:0] h, input logic [127:0] d, input logic iv,
                         output logic [127:0] res, output logic [3:0] hres, output int lat);
        a_data_in = {h, d}; a_inv = iv; a_in_valid = 1'b1; a_out_ready = 1'b1;
        step();
        a_in_valid = 1'b0;
        lat = 0;
        while (a_out_valid !== 1'b1 && lat < 20) begin step(); lat++; end
        res = a_data_out; hres = a_header_out;
        step();
    endtask

    task automatic run_b(input logic [3:0] h, input logic [127:0] d, input logic iv,
                         output logic [127:0] res, output logic [3:0] hres, output int lat,
                         output logic busy_rdy);
        b_data_in = {h, d}; b_inv = iv; b_in_valid = 1'b1; b_out_ready = 1'b1;
        step();
        b_in_valid = 1'b0;
        lat = 0; busy_rdy = 1'b0;
        while (b_out_valid !== 1'b1 && lat < 20) begin
            if (b_in_ready !== 1'b0) busy_rdy = 1'b1;
            step(); lat++;
        end
        res = b_data_out; hres = b_header_out;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        vectors++;
        if ({a_in_ready, b_in_ready} !== 2'b00) begin
            miscompares++; $display("FAIL rst_in_ready: got %b want 00", {a_in_ready, b_in_ready});
        end
        vectors++;
        if ({a_out_valid, a_header_out, a_data_out} !== 133'h0) begin
            miscompares++; $display("FAIL rst_outputs: got v=%b h=%h d=%h want all zero",
                                    a_out_valid, a_header_out, a_data_out);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if ({a_in_ready, b_in_ready, b_out_valid} !== 3'b110) begin
            miscompares++; $display("FAIL idle_after_rst: got %b want 110",
                                    {a_in_ready, b_in_ready, b_out_valid});
        end
    endtask

    task automatic test_forward();
        logic [127:0] res;
        logic [3:0]   h;
        int           lat;
        run_a(4'h7, {32'hd4bf5d30, 96'h0}, 1'b0, res, h, lat);
        vectors++;
        if (lat !== 1) begin miscompares++; $display("FAIL fwd_latency: got %0d want 1", lat); end
        vectors++;
        if (res !== {32'h046681e5, 96'h0}) begin
            miscompares++; $display("FAIL fwd_col3: got %h want %h", res, {32'h046681e5, 96'h0});
        end
        vectors++;
        if (h !== 4'h7) begin miscompares++; $display("FAIL fwd_header: got %h want 7", h); end

        run_a(4'h1, {4{32'hdb135345}}, 1'b0, res, h, lat);
        vectors++;
        if (res !== {4{32'h8e4da1bc}}) begin
            miscompares++; $display("FAIL fwd_db13: got %h want %h", res, {4{32'h8e4da1bc}});
        end
        run_a(4'h2, {4{32'hf20a225c}}, 1'b0, res, h, lat);
        vectors++;
        if (res !== {4{32'h9fdc589d}} || h !== 4'h2) begin
            miscompares++; $display("FAIL fwd_f20a: got %h/%h want %h/2", res, h, {4{32'h9fdc589d}});
        end
        run_a(4'hc, {32'hd4bf5d30, 32'hdb135345, 32'hf20a225c, 32'h01010101}, 1'b0, res, h, lat);
        vectors++;
        if (res !== {32'h046681e5, 32'h8e4da1bc, 32'h9fdc589d, 32'h01010101}) begin
            miscompares++; $display("FAIL fwd_mixed: got %h", res);
        end
    endtask

    task automatic test_inverse();
        logic [127:0] res;
        logic [3:0]   h;
        int           lat;
        run_a(4'h5, {32'h046681e5, 96'h0}, 1'b1, res, h, lat);
        vectors++;
        if (res !== {INV_COL, 96'h0} || h !== 4'h5) begin
            miscompares++; $display("FAIL inv_col3: got %h/%h want %h/5", res, h, {INV_COL, 96'h0});
        end
    endtask

    task automatic test_serial();
        logic [127:0] res;
        logic [3:0]   h;
        int           lat;
        logic         busy_rdy;
        run_b(4'h9, {32'hd4bf5d30, 32'hdb135345, 32'hf20a225c, 32'h01010101}, 1'b0,
              res, h, lat, busy_rdy);
        vectors++;
        if (lat !== 4) begin miscompares++; $display("FAIL serial_latency: got %0d want 4", lat); end
        vectors++;
        if (busy_rdy !== 1'b0) begin
            miscompares++; $display("FAIL serial_busy_ready: got %b want 0", busy_rdy);
        end
        vectors++;
        if (res !== {32'h046681e5, 32'h8e4da1bc, 32'h9fdc589d, 32'h01010101} || h !== 4'h9) begin
            miscompares++; $display("FAIL serial_result: got %h/%h", res, h);
        end
        run_b(4'ha, {32'h046681e5, 96'h0}, 1'b1, res, h, lat, busy_rdy);
        vectors++;
        if (res !== {INV_COL, 96'h0} || h !== 4'ha) begin
            miscompares++; $display("FAIL serial_inv: got %h/%h want %h/a", res, h, {INV_COL, 96'h0});
        end
    endtask

    task automatic test_back_pressure();
        logic [127:0] exp_a;
        exp_a = {4{32'h8e4da1bc}};
        a_out_ready = 1'b0;
        a_data_in = {4'h7, {4{32'hdb135345}}}; a_inv = 1'b0; a_in_valid = 1'b1;
        step();
        a_data_in = {4'h3, 32'h046681e5, 96'h0}; a_inv = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if ({a_in_ready, a_out_valid, a_header_out, a_data_out} !== {1'b0, 1'b1, 4'h7, exp_a}) begin
                miscompares++; $display("FAIL bp_hold[%0d]: got r=%b v=%b h=%h d=%h want r=0 v=1 h=7 d=%h",
                                        i, a_in_ready, a_out_valid, a_header_out, a_data_out, exp_a);
            end
            step();
        end
        a_out_ready = 1'b1;
        #1;
        vectors++;
        if (a_in_ready !== 1'b1) begin
            miscompares++; $display("FAIL bp_release_ready: got %b want 1", a_in_ready);
        end
        step();
        a_in_valid = 1'b0;
        vectors++;
        if (a_out_valid !== 1'b0) begin
            miscompares++; $display("FAIL bp_handoff_valid: got %b want 0", a_out_valid);
        end
        step();
        vectors++;
        if ({a_out_valid, a_header_out, a_data_out} !== {1'b1, 4'h3, INV_COL, 96'h0}) begin
            miscompares++; $display("FAIL bp_second: got v=%b h=%h d=%h want v=1 h=3 d=%h",
                                    a_out_valid, a_header_out, a_data_out, {INV_COL, 96'h0});
        end
        step();
    endtask

    task automatic test_reset_mid_busy();
        logic [127:0] res;
        logic [3:0]   h;
        int           lat;
        logic         busy_rdy;
        b_data_in = {4'hf, {4{32'hdb135345}}}; b_inv = 1'b0; b_in_valid = 1'b1; b_out_ready = 1'b1;
        step();
        b_in_valid = 1'b0;
        step(); step();
        rst = 1'b1;
        #1;
        vectors++;
        if ({b_out_valid, b_in_ready, b_header_out, b_data_out} !== 134'h0) begin
            miscompares++; $display("FAIL rst_mid_busy: got v=%b r=%b h=%h d=%h want all zero",
                                    b_out_valid, b_in_ready, b_header_out, b_data_out);
        end
        step();
        rst = 1'b0;
        #1;
        vectors++;
        if (b_in_ready !== 1'b1) begin
            miscompares++; $display("FAIL rst_mid_busy_idle: got %b want 1", b_in_ready);
        end
        run_b(4'h6, {4{32'hf20a225c}}, 1'b0, res, h, lat, busy_rdy);
        vectors++;
        if (res !== {4{32'h9fdc589d}} || h !== 4'h6 || lat !== 4) begin
            miscompares++; $display("FAIL post_rst_block: got %h/%h lat %0d want %h/6 lat 4",
                                    res, h, lat, {4{32'h9fdc589d}});
        end
    endtask

    initial begin
        a_in_valid = 1'b0; a_inv = 1'b0; a_out_ready = 1'b1; a_data_in = '0;
        b_in_valid = 1'b0; b_inv = 1'b0; b_out_ready = 1'b1; b_data_in = '0;
        test_reset();
        test_forward();
        test_inverse();
        test_serial();
        test_back_pressure();
        test_reset_mid_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
